// File: rtl/cohort_mshr_pkg.sv
// Shared constants, the MSHR index type and the ID range helper for the cohort MSHR arbiter.
package cohort_mshr_pkg;

    localparam int MSHR_BASE_DEF = 128;
    localparam int MSHR_NUM_DEF  = 16;
    localparam int MSHR_IDX_W    = 6;

    // Widest pool index (pool size is at most 64).
    typedef logic [MSHR_IDX_W-1:0] mshr_idx_t;

    // True when id lies inside the pool [base, base+num).
    function automatic logic mshr_in_range(input logic [7:0] id, input int base, input int num);
        int v;
        v = int'(id);
        return (v >= base) && (v < base + num);
    endfunction

endpackage

// File: rtl/cohort_mshr_arbiter_rr.sv
// Round-robin arbiter: picks the first requester at or after ptr, wrapping around.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          grant_valid
);

    int sel_s;

    // Scan requesters starting from the pointer and grant the first one found.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        sel_s       = 0;
        for (int i = 0; i < N; i++) begin
            sel_s = (int'(ptr) + i) % N;
            if (!grant_valid && req[sel_s]) begin
                grant_valid      = 1'b1;
                grant[sel_s]     = 1'b1;
                grant_idx        = PW'(sel_s);
            end else begin
                grant_valid      = grant_valid;
            end
        end
    end

endmodule

// File: rtl/cohort_mshr_arbiter.sv
// Shares one request channel and an MSHR ID pool among NUM_SRC requesters,
// tags each granted request with an ID and routes responses back to the owner.
module cohort_mshr_arbiter
    import cohort_mshr_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int PAYLOAD_W = 128,
    parameter int RESP_W    = 64,
    parameter int MSHR_BASE = MSHR_BASE_DEF,
    parameter int MSHR_NUM  = MSHR_NUM_DEF,
    parameter int MAX_OUT   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_SRC-1:0]             src_valid_i,
    output logic [NUM_SRC-1:0]             src_ready_o,
    input  logic [NUM_SRC*PAYLOAD_W-1:0]   src_payload_i,
    output logic                           sink_valid_o,
    input  logic                           sink_ready_i,
    output logic [PAYLOAD_W-1:0]           sink_payload_o,
    output logic [7:0]                     sink_mshrid_o,
    input  logic                           resp_valid_i,
    input  logic [7:0]                     resp_mshrid_i,
    input  logic [RESP_W-1:0]              resp_data_i,
    output logic [NUM_SRC-1:0]             dst_valid_o,
    output logic [RESP_W-1:0]              dst_data_o,
    output logic [$clog2(MSHR_NUM+1)-1:0]  inflight_o,
    output logic                           err_o
);

    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int IW = (MSHR_NUM > 1) ? $clog2(MSHR_NUM) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int FW = $clog2(MSHR_NUM + 1);

    logic [MSHR_NUM-1:0]  free_r;
    logic [MSHR_NUM-1:0]  free_next_s;
    logic [SW-1:0]        owner_r [MSHR_NUM];
    logic [CW-1:0]        cnt_r [NUM_SRC];
    logic [CW-1:0]        cnt_next_s [NUM_SRC];
    logic [SW-1:0]        ptr_r;
    logic                 slot_open_s;
    logic                 any_free_s;
    logic [IW-1:0]        alloc_idx_s;
    logic [NUM_SRC-1:0]   req_s;
    logic [NUM_SRC-1:0]   grant_s;
    logic [SW-1:0]        grant_idx_s;
    logic                 grant_any_s;
    logic                 resp_ok_s;
    logic [IW-1:0]        resp_idx_s;
    logic [SW-1:0]        resp_owner_s;
    logic [NUM_SRC-1:0]   dst_next_s;
    logic [FW-1:0]        inflight_next_s;
    logic [FW-1:0]        free_pop_s;
    logic [PAYLOAD_W-1:0] payload_sel_s;

    // Eligibility: source valid, below its cap, an ID available and the slot able to take it.
    always_comb begin
        any_free_s  = |free_r;
        slot_open_s = !sink_valid_o || sink_ready_i;
        for (int k = 0; k < NUM_SRC; k++) begin
            req_s[k] = src_valid_i[k] && (cnt_r[k] < CW'(MAX_OUT)) && any_free_s && slot_open_s;
        end
    end

    rr_arbiter #(
        .N  (NUM_SRC),
        .PW (SW)
    ) u_rr (
        .req         (req_s),
        .ptr         (ptr_r),
        .grant       (grant_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_any_s)
    );

    assign src_ready_o   = grant_s;
    assign payload_sel_s = src_payload_i[int'(grant_idx_s)*PAYLOAD_W +: PAYLOAD_W];

    // Lowest free index from the start-of-cycle free vector (IDs freed this cycle are not reused yet).
    always_comb begin
        alloc_idx_s = '0;
        for (int i = MSHR_NUM - 1; i >= 0; i--) begin
            if (free_r[i]) begin
                alloc_idx_s = IW'(i);
            end else begin
                alloc_idx_s = alloc_idx_s;
            end
        end
    end

    // Response validation: in the pool and currently allocated.
    always_comb begin
        resp_idx_s   = IW'(resp_mshrid_i - 8'(MSHR_BASE));
        resp_ok_s    = resp_valid_i && mshr_in_range(resp_mshrid_i, MSHR_BASE, MSHR_NUM)
                       && !free_r[resp_idx_s];
        resp_owner_s = owner_r[resp_idx_s];
        for (int k = 0; k < NUM_SRC; k++) begin
            dst_next_s[k] = resp_ok_s && (resp_owner_s == SW'(k));
        end
    end

    // Next free vector, per-source counters and the resulting in-flight count.
    always_comb begin
        free_next_s = free_r;
        if (grant_any_s) begin
            free_next_s[alloc_idx_s] = 1'b0;
        end else begin
            free_next_s = free_next_s;
        end
        if (resp_ok_s) begin
            free_next_s[resp_idx_s] = 1'b1;
        end else begin
            free_next_s = free_next_s;
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            if (grant_s[k] && !dst_next_s[k]) begin
                cnt_next_s[k] = cnt_r[k] + CW'(1);
            end else if (!grant_s[k] && dst_next_s[k]) begin
                cnt_next_s[k] = cnt_r[k] - CW'(1);
            end else begin
                cnt_next_s[k] = cnt_r[k];
            end
        end
        free_pop_s = '0;
        for (int i = 0; i < MSHR_NUM; i++) begin
            free_pop_s = free_pop_s + FW'(free_next_s[i]);
        end
        inflight_next_s = FW'(MSHR_NUM) - free_pop_s;
    end

    // State and registered outputs: slot, ID bookkeeping, response routing and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sink_valid_o   <= 1'b0;
            sink_payload_o <= '0;
            sink_mshrid_o  <= 8'd0;
            free_r         <= '1;
            ptr_r          <= '0;
            dst_valid_o    <= '0;
            dst_data_o     <= '0;
            inflight_o     <= '0;
            err_o          <= 1'b0;
            for (int i = 0; i < MSHR_NUM; i++) begin
                owner_r[i] <= '0;
            end
            for (int k = 0; k < NUM_SRC; k++) begin
                cnt_r[k] <= '0;
            end
        end else begin
            if (grant_any_s) begin
                sink_valid_o          <= 1'b1;
                sink_payload_o        <= payload_sel_s;
                sink_mshrid_o         <= 8'(MSHR_BASE) + 8'(mshr_idx_t'(alloc_idx_s));
                owner_r[alloc_idx_s]  <= grant_idx_s;
                ptr_r                 <= (grant_idx_s == SW'(NUM_SRC - 1)) ? '0 : grant_idx_s + SW'(1);
            end else if (sink_ready_i) begin
                sink_valid_o <= 1'b0;
            end else begin
                sink_valid_o <= sink_valid_o;
            end
            if (resp_ok_s) begin
                dst_data_o <= resp_data_i;
            end else begin
                dst_data_o <= dst_data_o;
            end
            free_r      <= free_next_s;
            dst_valid_o <= dst_next_s;
            inflight_o  <= inflight_next_s;
            err_o       <= err_o || (resp_valid_i && !resp_ok_s);
            for (int k = 0; k < NUM_SRC; k++) begin
                cnt_r[k] <= cnt_next_s[k];
            end
        end
    end

endmodule

// File: tb/tb_cohort_mshr_arbiter.sv
// Self-checking bench for cohort_mshr_arbiter: directed scenarios followed by a random phase,
// all checked against an ID-ownership model kept in the bench.
module tb_cohort_mshr_arbiter;

    localparam int NS = 4;
    localparam int PW = 128;
    localparam int RW = 64;
    localparam int BASE = 128;
    localparam int NUM = 16;
    localparam int CAP = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NS-1:0]     src_valid = '0;
    logic [NS-1:0]     src_ready_o;
    logic [NS*PW-1:0]  src_payload = '0;
    logic              sink_valid_o;
    logic              sink_ready = 1'b1;
    logic [PW-1:0]     sink_payload_o;
    logic [7:0]        sink_mshrid_o;
    logic              resp_valid = 1'b0;
    logic [7:0]        resp_id = 8'd0;
    logic [RW-1:0]     resp_data = '0;
    logic [NS-1:0]     dst_valid_o;
    logic [RW-1:0]     dst_data_o;
    logic [4:0]        inflight_o;
    logic              err_o;

    cohort_mshr_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .src_valid_i    (src_valid),
        .src_ready_o    (src_ready_o),
        .src_payload_i  (src_payload),
        .sink_valid_o   (sink_valid_o),
        .sink_ready_i   (sink_ready),
        .sink_payload_o (sink_payload_o),
        .sink_mshrid_o  (sink_mshrid_o),
        .resp_valid_i   (resp_valid),
        .resp_mshrid_i  (resp_id),
        .resp_data_i    (resp_data),
        .dst_valid_o    (dst_valid_o),
        .dst_data_o     (dst_data_o),
        .inflight_o     (inflight_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: owner per pool slot (-1 = free), outstanding count per source.
    int            m_owner [NUM];
    int            m_cnt [NS];
    int            m_ptr;
    bit            m_slot_v;
    logic [PW-1:0] m_slot_pay;
    int            m_slot_id;
    logic [NS-1:0] m_dst;
    logic [RW-1:0] m_dst_data;
    bit            m_err;
    int            last_grant;
    logic [NS-1:0] last_rdy;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM; i++) m_owner[i] = -1;
        for (int k = 0; k < NS; k++) m_cnt[k] = 0;
        m_ptr = 0; m_slot_v = 0; m_slot_pay = '0; m_slot_id = 0;
        m_dst = '0; m_dst_data = '0; m_err = 0;
    endtask

    function automatic int n_alloc();
        int c = 0;
        for (int i = 0; i < NUM; i++) if (m_owner[i] >= 0) c++;
        return c;
    endfunction

    // One clock: called just after a negedge with inputs set; returns at the next negedge.
    task automatic step();
        int g = -1; int lowf = -1; int rown; int ridx;
        bit open; bit rok = 0;
        #1;
        open = !m_slot_v || sink_ready;
        for (int i = NUM - 1; i >= 0; i--) if (m_owner[i] < 0) lowf = i;
        if (open && lowf >= 0) begin
            for (int i = 0; i < NS; i++) begin
                int k = (m_ptr + i) % NS;
                if (g < 0 && src_valid[k] && m_cnt[k] < CAP) g = k;
            end
        end
        last_grant = g;
        last_rdy   = src_ready_o;
        chk("ready", src_ready_o, (g >= 0) ? (4'b0001 << g) : 4'b0000);
        if (resp_valid) begin
            if (resp_id >= BASE && resp_id < BASE + NUM && m_owner[resp_id - BASE] >= 0) rok = 1;
            else m_err = 1;
        end
        @(posedge clk);
        if (m_slot_v && sink_ready) m_slot_v = 0;
        m_dst = '0;
        if (rok) begin
            ridx = resp_id - BASE;
            rown = m_owner[ridx];
            m_dst[rown] = 1'b1;
            m_dst_data = resp_data;
            m_owner[ridx] = -1;
            m_cnt[rown]--;
        end
        if (g >= 0) begin
            m_slot_v = 1;
            m_slot_pay = src_payload[g*PW +: PW];
            m_slot_id = BASE + lowf;
            m_owner[lowf] = g;
            m_cnt[g]++;
            m_ptr = (g + 1) % NS;
        end
        @(negedge clk);
        chk("sink_valid", sink_valid_o, m_slot_v);
        if (m_slot_v) begin
            chk("sink_payload", sink_payload_o, m_slot_pay);
            chk("sink_id", sink_mshrid_o, m_slot_id);
        end
        chk("dst_valid", dst_valid_o, m_dst);
        if (m_dst != '0) chk("dst_data", dst_data_o, m_dst_data);
        chk("inflight", inflight_o, n_alloc());
        chk("err", err_o, m_err);
    endtask

    task automatic do_reset();
        rst = 1'b1; src_valid = '0; resp_valid = 1'b0; sink_ready = 1'b1;
        #1;
        chk("rst_sink_valid", sink_valid_o, 1'b0);
        chk("rst_dst_valid", dst_valid_o, 4'b0000);
        chk("rst_inflight", inflight_o, 5'd0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_ready", src_ready_o, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    function automatic int lowest_alloc();
        for (int i = 0; i < NUM; i++) if (m_owner[i] >= 0) return BASE + i;
        return -1;
    endfunction

    int acc;

    initial begin
        model_clear();
        @(negedge clk);
        do_reset();

        // Single request then its response.
        src_payload[0 +: PW] = 128'hA5;
        src_valid = 4'b0001;
        step();
        chk("t1_ready", last_rdy, 4'b0001);
        chk("t1_sink_valid", sink_valid_o, 1'b1);
        chk("t1_id", sink_mshrid_o, 8'd128);
        chk("t1_payload", sink_payload_o, 128'hA5);
        chk("t1_inflight", inflight_o, 5'd1);
        src_valid = '0; resp_valid = 1'b1; resp_id = 8'd128; resp_data = 64'h1234;
        step();
        resp_valid = 1'b0;
        chk("t1_dst", dst_valid_o, 4'b0001);
        chk("t1_dst_data", dst_data_o, 64'h1234);
        chk("t1_inflight0", inflight_o, 5'd0);

        // Fairness with immediate responses.
        do_reset();
        src_valid = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            int id = lowest_alloc();
            resp_valid = (id >= 0); resp_id = 8'(id); resp_data = 64'(i);
            step();
            chk("fair_order", last_grant, i % NS);
        end
        resp_valid = 1'b0;

        // Pool exhaustion and reuse of a returned ID.
        do_reset();
        src_valid = 4'b1111;
        for (int i = 0; i < 16; i++) step();
        step();
        chk("exh_ready", last_rdy, 4'b0000);
        chk("exh_inflight", inflight_o, 5'd16);
        resp_valid = 1'b1; resp_id = 8'd133; resp_data = 64'hBEEF;
        step();
        resp_valid = 1'b0;
        step();
        chk("exh_reuse_id", sink_mshrid_o, 8'd133);

        // Per-source cap.
        do_reset();
        src_valid = 4'b0100; acc = 0;
        for (int i = 0; i < 8; i++) begin step(); if (last_grant == 2) acc++; end
        chk("cap_first", acc, 4);
        resp_valid = 1'b1; resp_id = 8'd130;
        step(); if (last_grant == 2) acc++;
        resp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin step(); if (last_grant == 2) acc++; end
        chk("cap_after_resp", acc, 5);

        // Backpressure holds the slot.
        do_reset();
        src_payload[0 +: PW] = 128'hCAFE;
        src_valid = 4'b0001;
        step();
        sink_ready = 1'b0; src_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_no_grant", last_rdy, 4'b0000);
            chk("bp_id_hold", sink_mshrid_o, 8'd128);
            chk("bp_pay_hold", sink_payload_o, 128'hCAFE);
        end
        sink_ready = 1'b1;
        step();
        chk("bp_rise", last_rdy, 4'b0010);

        // Invalid response, sticky error, reset mid-operation.
        do_reset();
        resp_valid = 1'b1; resp_id = 8'd200;
        step();
        resp_valid = 1'b0;
        chk("err_no_dst", dst_valid_o, 4'b0000);
        chk("err_set", err_o, 1'b1);
        src_valid = 4'b0001;
        for (int i = 0; i < 3; i++) step();
        chk("err_sticky", err_o, 1'b1);
        chk("pre_rst_inflight", inflight_o, 5'd3);
        do_reset();
        resp_valid = 1'b1; resp_id = 8'd128;
        step();
        resp_valid = 1'b0;
        chk("stale_err", err_o, 1'b1);

        // Random phase.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            int r;
            src_valid  = 4'($urandom_range(0, 15));
            sink_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NS; k++)
                src_payload[k*PW +: PW] = {$urandom, $urandom, $urandom, $urandom};
            resp_data = {$urandom, $urandom};
            r = $urandom_range(0, 99);
            resp_valid = 1'b0;
            if (r < 50 && n_alloc() > 0) begin
                int pick = $urandom_range(0, n_alloc() - 1);
                for (int i = 0; i < NUM; i++) begin
                    if (m_owner[i] >= 0) begin
                        if (pick == 0) begin resp_valid = 1'b1; resp_id = 8'(BASE + i); end
                        pick--;
                    end
                end
            end else if (r < 52) begin
                resp_valid = 1'b1; resp_id = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 249) == 0) do_reset();
            else step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cohort_mshr_arbiter.md
Name: cohort_mshr_arbiter

Overview:
Shares one memory-request channel and one pool of MSHR IDs among NUM_SRC requesters (FIFO controllers, coherency managers) inside a cohort tile.
- Arbitrates requests round-robin.
- Allocates an MSHR ID from a contiguous pool to each granted request and tags the request with it.
- Tracks the owner of every in-flight ID.
- Routes each returning response to its originating source, then frees the ID.
- Sits between the per-consumer request producers and the address translator.

Parameters:
NUM_SRC, 4, number of requesters (2..16)
PAYLOAD_W, 128, opaque request payload width (address/type/size/data packed by the caller)
RESP_W, 64, response data width
MSHR_BASE, 128, first MSHR ID in the pool
MSHR_NUM, 16, number of IDs in the pool (power of 2, ≤64)
MAX_OUT, 4, maximum in-flight IDs per source

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
src_valid_i  in  NUM_SRC  per-source request valid
src_ready_o  out  NUM_SRC  per-source accept; transfer = valid & ready
src_payload_i  in  NUM_SRC*PAYLOAD_W  packed payloads; source k occupies [k*PAYLOAD_W +: PAYLOAD_W]
sink_valid_o  out  1  request to translator valid
sink_ready_i  in  1  translator accept
sink_payload_o  out  PAYLOAD_W  granted payload
sink_mshrid_o  out  8  allocated MSHR ID
resp_valid_i  in  1  response valid (always accepted)
resp_mshrid_i  in  8  response MSHR ID
resp_data_i  in  RESP_W  response data
dst_valid_o  out  NUM_SRC  one-hot response pulse to the owning source
dst_data_o  out  RESP_W  response data (shared by all sources)
inflight_o  out  $clog2(MSHR_NUM+1)  number of allocated IDs
err_o  out  1  sticky: response received for an unallocated or out-of-range ID

Behaviour:
Reset values:
- All outputs 0.
- Free vector all-ones.
- Owner table 0; per-source counters 0.
- RR pointer 0.

Output slot:
- Single register slot carrying payload + ID.
- The slot is "open" if it is empty, or if sink_valid_o & sink_ready_i this cycle.
- Held stable while sink_valid_o & !sink_ready_i.

Eligibility and grant:
- Source k is eligible when all hold: src_valid_i[k], cnt[k] < MAX_OUT, at least one free ID, and the slot is open.
- Grant goes to the first eligible source at or after the RR pointer (wrapping).
- src_ready_o[grant] = 1, combinational, same cycle. All other readies are 0.
- Nothing is granted if no ID is free or the slot is not open.

Per-grant updates (next edge):
- Slot loads the payload and ID = MSHR_BASE + lowest free index.
- That index is cleared in the free vector.
- owner[idx] = k; cnt[k]++.
- RR pointer = k+1 mod NUM_SRC.

Responses:
- A response is valid when resp_valid_i is set and resp_mshrid_i is in [MSHR_BASE, MSHR_BASE+MSHR_NUM) with that index allocated.
- Next cycle: dst_valid_o[owner] = 1 and dst_data_o = registered resp_data_i. Latency is exactly 1 cycle.
- On the same edge the index is set free and cnt[owner]--.
- Invalid response: dropped, no dst pulse, err_o set until reset.

Simultaneous events:
- Allocation uses the free vector as of the start of the cycle, so an ID freed this cycle is not re-issued until the next cycle.
- Grant and response for the same source in one cycle leave cnt unchanged.
- Counters never underflow or overflow.

Request/response ordering:
- A response may arrive while its request is still in the slot (speculative translator). It is honoured, since the ID is already allocated.

inflight_o = MSHR_NUM - popcount(free), registered.

Reset mid-operation:
- All IDs are freed and the slot is cleared.
- Responses arriving later for old IDs are invalid and set err_o.

Decomposition:
Package cohort_mshr_pkg holds:
- MSHR_BASE/MSHR_NUM defaults.
- mshr_idx_t typedef.
- A function mshr_in_range(id).

Sub-module rr_arbiter (NUM_SRC, req, ptr → one-hot grant, index) is factored out and reusable. ID allocation (priority encoder over the free vector) stays inline.

Test Plan:
- Reset then single request: src0 valid, payload 0xA5 → same-cycle ready; next cycle sink_valid_o=1, mshrid 128; inflight_o=1. Response id 128, data 0x1234 → dst_valid_o=0001 one cycle later, dst_data_o=0x1234, inflight_o=0.
- Fairness: all 4 sources valid continuously, sink_ready_i=1, responses returned immediately → grant order 0,1,2,3,0,...; no source ever granted twice within 4 grants.
- Pool exhaustion: 16 grants with no responses → src_ready_o all 0 and inflight_o=16. Return id 133 → next grant gets id 133.
- Per-source cap: only src2 requests, no responses → exactly 4 accepted (ids 128–131), then ready stays 0; one response → exactly one more accepted.
- Backpressure: sink_ready_i=0 for 5 cycles with slot full → payload/ID held stable, no grants; ready rises the cycle sink_ready_i=1 is sampled.
- Error/reset: response id 200 → no dst pulse, err_o=1 sticky. Assert rst with 3 in flight → inflight_o=0, err_o=0; a later response id 128 sets err_o.
